// File: rtl/jzjpcc_mmio_uart_tx.sv
// Toggle-handshake MMIO UART transmitter (8N1, LSB first, tx idles high).
// Define JZJPCC_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module jzjpcc_mmio_uart_tx #(
  parameter int CLOCKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] txCommand,
  output logic [31:0] txStatus,
  output logic        tx
);

  localparam int BW = $clog2(CLOCKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef JZJPCC_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            ack_q, ack_d;
  logic            tx_q, tx_d;
  logic            baud_end;
  logic            request;

  // Bits 31:9 of the command word carry nothing for this block.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^txCommand[31:9];

  assign baud_end = (baud_q == BAUD_LAST);
  assign request  = (txCommand[8] != ack_q);

  // tx_d is derived from the state being entered so tx changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    ack_d   = ack_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (request) begin
          data_d  = txCommand[7:0];
          ack_d   = txCommand[8];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          state_d = DATA;
          tx_d    = data_q[bit_q];
        end
      end
      DATA: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef JZJPCC_UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^data_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = data_q[bit_d];
          end
        end
      end
`ifdef JZJPCC_UART_TX_PARITY_EN
      PARITY: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Reset adopts the current request toggle so nothing is pending afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      ack_q   <= txCommand[8];
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      tx_q    <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign txStatus = {30'b0, ack_q, (state_q != IDLE)};

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// Self-checking bench for jzjpcc_mmio_uart_tx (CLOCKS_PER_BIT=4) against a frame-level model.
// Honours JZJPCC_UART_TX_PARITY_EN the same way as the design.
module tb_jzjpcc_mmio_uart_tx;

  localparam int CPB = 4;
`ifdef JZJPCC_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYCLES = FRAME_BITS * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] txCommand = 32'h0;
  logic [31:0] txStatus;
  logic        tx;

  int vectors = 0;
  int miscompares = 0;

  // Model: a frame is a list of line bits, each held CPB cycles from the accepting edge.
  logic        m_ack = 1'b0;
  logic        m_busy = 1'b0;
  int          m_off = 0;
  logic        m_bits [FRAME_BITS];
  logic        m_tx = 1'b1;
  logic [31:0] m_status = 32'h0;

  jzjpcc_mmio_uart_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock    (clock),
    .reset    (reset),
    .txCommand(txCommand),
    .txStatus (txStatus),
    .tx       (tx)
  );

  always #5 clock = ~clock;

  task automatic advance();
    logic [31:0] cmd;
    logic        rst;
    cmd = txCommand;
    rst = reset;
    @(posedge clock);
    #1;
    if (rst) begin
      m_ack  = cmd[8];
      m_busy = 1'b0;
      m_off  = 0;
    end else if (m_busy) begin
      m_off++;
      if (m_off == FRAME_CYCLES) m_busy = 1'b0;
    end else if (cmd[8] != m_ack) begin
      m_ack  = cmd[8];
      m_busy = 1'b1;
      m_off  = 0;
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[i + 1] = cmd[i];
`ifdef JZJPCC_UART_TX_PARITY_EN
      m_bits[9] = ^cmd[7:0];
`endif
      m_bits[FRAME_BITS - 1] = 1'b1;
    end
    m_tx     = m_busy ? m_bits[m_off / CPB] : 1'b1;
    m_status = {30'b0, m_ack, m_busy};
  endtask

  task automatic do_reset(input logic [31:0] cmd);
    txCommand = cmd;
    reset = 1'b1;
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int low_seen;
    do_reset(32'h100);
    vectors++;
    if (tx !== 1'b1 || txStatus !== 32'h2) begin
      miscompares++;
      $display("[TB] FAIL reset_state: tx=%b status=%h, required tx=1 status=00000002", tx, txStatus);
    end
    low_seen = 0;
    repeat (100) begin
      advance();
      if (tx === 1'b0 || txStatus[0] === 1'b1) low_seen++;
      vectors++;
      if (tx !== m_tx || txStatus !== m_status) begin
        miscompares++;
        $display("[TB] FAIL reset_hold: tx=%b status=%h, required tx=%b status=%h", tx, txStatus, m_tx, m_status);
      end
    end
    vectors++;
    if (low_seen !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_frame: active cycles=%0d, required 0", low_seen);
    end
  endtask

  task automatic test_single_frame();
    int busy_cycles;
    do_reset(32'h0);
    txCommand = 32'h155;
    advance();
    busy_cycles = txStatus[0] ? 1 : 0;
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_start: tx=%b, required 0", tx);
    end
    repeat (FRAME_CYCLES + 5) begin
      advance();
      if (txStatus[0] === 1'b1) busy_cycles++;
      vectors++;
      if (tx !== m_tx || txStatus !== m_status) begin
        miscompares++;
        $display("[TB] FAIL single_frame: tx=%b status=%h, required tx=%b status=%h", tx, txStatus, m_tx, m_status);
      end
    end
    vectors++;
    if (busy_cycles !== FRAME_CYCLES) begin
      miscompares++;
      $display("[TB] FAIL single_busy_len: busy=%0d, required %0d", busy_cycles, FRAME_CYCLES);
    end
    vectors++;
    if (txStatus !== 32'h2) begin
      miscompares++;
      $display("[TB] FAIL single_final_status: status=%h, required 00000002", txStatus);
    end
  endtask

  task automatic test_back_to_back();
    int  fall_at, rise_at, c;
    logic prev_busy;
    do_reset(32'h0);
    txCommand = 32'h155;
    fall_at = -1;
    rise_at = -1;
    prev_busy = 1'b0;
    c = 0;
    repeat (2 * FRAME_CYCLES + 20) begin
      if (c == 10) txCommand = 32'h0A3;
      advance();
      if (prev_busy && txStatus[0] === 1'b0 && fall_at < 0) fall_at = c;
      if (!prev_busy && txStatus[0] === 1'b1 && fall_at >= 0 && rise_at < 0) rise_at = c;
      prev_busy = txStatus[0];
      c++;
      vectors++;
      if (tx !== m_tx || txStatus !== m_status) begin
        miscompares++;
        $display("[TB] FAIL back_to_back: tx=%b status=%h, required tx=%b status=%h", tx, txStatus, m_tx, m_status);
      end
    end
    vectors++;
    if (fall_at < 0 || rise_at - fall_at !== 1) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_gap: gap=%0d, required 1", rise_at - fall_at);
    end
    vectors++;
    if (txStatus !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_status: status=%h, required 00000000", txStatus);
    end
  endtask

  task automatic test_double_flip();
    int  starts, c;
    logic prev_busy;
    do_reset(32'h0);
    txCommand = 32'h155;
    starts = 0;
    prev_busy = 1'b0;
    c = 0;
    repeat (2 * FRAME_CYCLES + 20) begin
      if (c == 5)  txCommand = 32'h0FF;
      if (c == 12) txCommand = 32'h1AA;
      advance();
      if (!prev_busy && txStatus[0] === 1'b1) starts++;
      prev_busy = txStatus[0];
      c++;
      vectors++;
      if (tx !== m_tx || txStatus !== m_status) begin
        miscompares++;
        $display("[TB] FAIL double_flip: tx=%b status=%h, required tx=%b status=%h", tx, txStatus, m_tx, m_status);
      end
    end
    vectors++;
    if (starts !== 1) begin
      miscompares++;
      $display("[TB] FAIL double_flip_frames: frames=%0d, required 1", starts);
    end
  endtask

  task automatic test_reset_abort();
    int active;
    do_reset(32'h0);
    txCommand = 32'h155;
    repeat (18) begin
      advance();
      vectors++;
      if (tx !== m_tx || txStatus !== m_status) begin
        miscompares++;
        $display("[TB] FAIL abort_pre: tx=%b status=%h, required tx=%b status=%h", tx, txStatus, m_tx, m_status);
      end
    end
    reset = 1'b1;
    advance();
    reset = 1'b0;
    vectors++;
    if (tx !== 1'b1 || txStatus[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_reset: tx=%b busy=%b, required tx=1 busy=0", tx, txStatus[0]);
    end
    active = 0;
    repeat (60) begin
      advance();
      if (txStatus[0] === 1'b1 || tx === 1'b0) active++;
      vectors++;
      if (tx !== m_tx || txStatus !== m_status) begin
        miscompares++;
        $display("[TB] FAIL abort_post: tx=%b status=%h, required tx=%b status=%h", tx, txStatus, m_tx, m_status);
      end
    end
    vectors++;
    if (active !== 0) begin
      miscompares++;
      $display("[TB] FAIL abort_resume: active cycles=%0d, required 0", active);
    end
  endtask

`ifdef JZJPCC_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [2];
    logic       par [2];
    bytes[0] = 8'h07; par[0] = 1'b1;
    bytes[1] = 8'h03; par[1] = 1'b0;
    do_reset(32'h0);
    for (int f = 0; f < 2; f++) begin
      txCommand = {23'b0, ~txCommand[8], bytes[f]};
      advance();
      for (int k = 1; k <= FRAME_CYCLES; k++) begin
        advance();
        vectors++;
        if (tx !== m_tx || txStatus !== m_status) begin
          miscompares++;
          $display("[TB] FAIL parity_frame: tx=%b status=%h, required tx=%b status=%h", tx, txStatus, m_tx, m_status);
        end
        if (k == 9 * CPB + 1) begin
          vectors++;
          if (tx !== par[f]) begin
            miscompares++;
            $display("[TB] FAIL parity_bit: byte=%h tx=%b, required %b", bytes[f], tx, par[f]);
          end
        end
        if (k == 10 * CPB + 1) begin
          vectors++;
          if (tx !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL parity_stop: byte=%h tx=%b, required 1", bytes[f], tx);
          end
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] r;
    do_reset($urandom());
    repeat (3000) begin
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom();
        txCommand = {r[31:9], r[8] ? ~txCommand[8] : txCommand[8], r[7:0]};
      end
      advance();
      vectors++;
      if (tx !== m_tx || txStatus !== m_status) begin
        miscompares++;
        $display("[TB] FAIL random: tx=%b status=%h, required tx=%b status=%h", tx, txStatus, m_tx, m_status);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_double_flip();
    test_reset_abort();
`ifdef JZJPCC_UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
